// File: rtl/csr_access_unit.sv
// Execute-stage read-modify-write sequencer for Zicsr instructions, fronting the CSR file.
// Optional build macro CSR_RO_TRAP_EN: trap writes to read-only CSR space (addr[11:10]==2'b11).
module csr_access_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] csr_addr_in,
    input  logic [4:0]        rs1_field,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   csr_readbus,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [XLEN-1:0]   data_in,
    output logic              write_en,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   rd_data,
    output logic              rd_we,
    output logic              illegal
);

    localparam int unsigned OP_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MODIFY,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [OP_W-1:0]   op;
    logic [4:0]        rs1_idx;
    logic [XLEN-1:0]   operand;
    logic [XLEN-1:0]   old_val;

    logic              start_ok_c;
    logic              bad_funct3_c;
    logic              ro_trap_c;
    logic              do_write_c;
    logic              illegal_next_c;
    logic [XLEN-1:0]   new_val_c;

    // State register
    always_ff @(posedge clk) begin
        if (resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and read-modify-write arithmetic
    always_comb begin
        state_next     = state;
        start_ok_c     = 1'b0;
        bad_funct3_c   = 1'b0;
        ro_trap_c      = 1'b0;
        do_write_c     = 1'b0;
        new_val_c      = '0;
        illegal_next_c = illegal;

        case (state)
            S_IDLE: begin
                if (start) begin
                    start_ok_c = 1'b1;
                    if (funct3[1:0] == 2'b00) begin
                        bad_funct3_c = 1'b1;
                        state_next   = S_DONE;
                    end else begin
                        state_next = S_READ;
                    end
                end
            end
            S_READ: begin
                state_next = S_MODIFY;
            end
            S_MODIFY: begin
                case (op)
                    2'b10:   new_val_c = old_val | operand;
                    2'b11:   new_val_c = old_val & ~operand;
                    default: new_val_c = operand;
                endcase
                // Set/clear with x0/zimm=0 is a pure read: no write side effect
                do_write_c = (op == 2'b01) || (rs1_idx != 5'd0);
                if (do_write_c) begin
`ifdef CSR_RO_TRAP_EN
                    if (csr_addr[ADDR_W-1 -: 2] == 2'b11) begin
                        ro_trap_c  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_WRITE;
                    end
`else
                    state_next = S_WRITE;
`endif
                end else begin
                    state_next = S_DONE;
                end
            end
            S_WRITE: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (start_ok_c) begin
            illegal_next_c = bad_funct3_c;
        end else if (ro_trap_c) begin
            illegal_next_c = 1'b1;
        end
    end

    // Operand latches and registered outputs, all derived from the next state
    always_ff @(posedge clk) begin
        if (resetn) begin
            op       <= '0;
            rs1_idx  <= '0;
            operand  <= '0;
            old_val  <= '0;
            csr_addr <= '0;
            data_in  <= '0;
            write_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= '0;
            rd_we    <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            if (start_ok_c) begin
                op       <= funct3[1:0];
                rs1_idx  <= rs1_field;
                operand  <= funct3[2] ? XLEN'(rs1_field) : rs1_data;
                old_val  <= '0;
                csr_addr <= csr_addr_in;
            end
            if (state == S_READ) begin
                old_val <= csr_readbus;
            end
            if (state_next == S_WRITE) begin
                data_in <= new_val_c;
            end
            if (state_next == S_DONE) begin
                rd_data <= start_ok_c ? '0 : old_val;
            end
            illegal  <= illegal_next_c;
            write_en <= (state_next == S_WRITE);
            done     <= (state_next == S_DONE);
            rd_we    <= (state_next == S_DONE) && !illegal_next_c;
            busy     <= (state_next == S_READ) || (state_next == S_MODIFY) ||
                        (state_next == S_WRITE);
        end
    end

endmodule
